// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: multiplexed seven-segment display lines as seen from the driver and the monitor
interface seg7_scan_decoder_if #(parameter int DIGITS = 3);
    logic [6:0]        seg;
    logic              dp;
    logic [DIGITS-1:0] digit_en;
    modport master(output seg, dp, digit_en);
    modport slave(input seg, dp, digit_en);
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples multiplexed seg/dp/digit_en lines and rebuilds the displayed hex value per digit
module seg7_scan_decoder #(
    parameter int DIGITS        = 3,
    parameter bit INVERT_DIGITS = 1'b0,
    parameter bit INVERT_SEGS   = 1'b0,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_scan_decoder_if.slave    disp,
    input  logic                  clear_i,
    output logic [4*DIGITS-1:0]   value_o,
    output logic [DIGITS-1:0]     dp_o,
    output logic [DIGITS-1:0]     digit_valid_o,
    output logic                  frame_o,
    output logic                  ghost_err_o
);
    localparam int W  = DIGITS + 8;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    logic [W-1:0]      norm, s1, s2, prev;
    logic [CW-1:0]     cnt, cnt_next;
    logic [DIGITS-1:0] en, seen, seen_next;
    logic              capture, one_hot, ghost, seen_all;
    logic [4:0]        hex;
    function automatic logic [4:0] hex_decode(input logic [6:0] s);
        case (s)
            7'h3F: return 5'h10;
            7'h06: return 5'h11;
            7'h5B: return 5'h12;
            7'h4F: return 5'h13;
            7'h66: return 5'h14;
            7'h6D: return 5'h15;
            7'h7D: return 5'h16;
            7'h07: return 5'h17;
            7'h7F: return 5'h18;
            7'h6F: return 5'h19;
            7'h77: return 5'h1A;
            7'h7C: return 5'h1B;
            7'h39: return 5'h1C;
            7'h5E: return 5'h1D;
            7'h79: return 5'h1E;
            7'h71: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction
    assign norm = {disp.digit_en ^ {DIGITS{INVERT_DIGITS}}, {disp.dp, disp.seg} ^ {8{INVERT_SEGS}}};
    // s2 equals prev whenever the counter advances, so s2 is the pattern being captured
    always_comb begin
        en        = s2[W-1:8];
        hex       = hex_decode(s2[6:0]);
        ghost     = (en & (en - DIGITS'(1))) != '0;
        one_hot   = en != '0 && !ghost;
        capture   = s2 == prev && cnt == CW'(STABLE_CYCLES - 1);
        cnt_next  = s2 != prev ? '0 : cnt == CW'(STABLE_CYCLES) ? cnt : cnt + CW'(1);
        seen_next = seen | en;
        seen_all  = &seen_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1            <= '0;
            s2            <= '0;
            prev          <= '0;
            cnt           <= '0;
            seen          <= '0;
            value_o       <= '0;
            dp_o          <= '0;
            digit_valid_o <= '0;
            frame_o       <= 1'b0;
            ghost_err_o   <= 1'b0;
        end else begin
            s1      <= norm;
            s2      <= s1;
            prev    <= s2;
            frame_o <= 1'b0;
            if (clear_i) begin
                cnt           <= '0;
                seen          <= '0;
                value_o       <= '0;
                dp_o          <= '0;
                digit_valid_o <= '0;
                ghost_err_o   <= 1'b0;
            end else begin
                cnt <= cnt_next;
                if (capture && ghost)
                    ghost_err_o <= 1'b1;
                if (capture && one_hot) begin
                    for (int i = 0; i < DIGITS; i++)
                        if (en[i]) begin
                            if (hex[4])
                                value_o[4*i +: 4] <= hex[3:0];
                            digit_valid_o[i] <= hex[4];
                            dp_o[i]          <= s2[7];
                        end
                    seen    <= seen_all ? '0 : seen_next;
                    frame_o <= seen_all;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: scoreboard bench for the seven-segment scan decoder, plain and inverted polarity
module tb_seg7_scan_decoder;
    localparam int D = 3;
    logic clk = 1'b0, rst = 1'b1, clear = 1'b0;
    always #5 clk = ~clk;
    seg7_scan_decoder_if #(.DIGITS(D)) bus();
    seg7_scan_decoder_if #(.DIGITS(D)) bus_inv();
    logic [4*D-1:0] value_o, value_inv;
    logic [D-1:0]   dp_o, dp_inv, valid_o, valid_inv;
    logic           frame_o, frame_inv, ghost_o, ghost_inv;
    seg7_scan_decoder #(.DIGITS(D), .INVERT_DIGITS(1'b0), .INVERT_SEGS(1'b0), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .disp(bus), .clear_i(clear), .value_o(value_o), .dp_o(dp_o),
        .digit_valid_o(valid_o), .frame_o(frame_o), .ghost_err_o(ghost_o));
    seg7_scan_decoder #(.DIGITS(D), .INVERT_DIGITS(1'b1), .INVERT_SEGS(1'b1), .STABLE_CYCLES(4)) dut_inv (
        .clk(clk), .rst(rst), .disp(bus_inv), .clear_i(1'b0), .value_o(value_inv), .dp_o(dp_inv),
        .digit_valid_o(valid_inv), .frame_o(frame_inv), .ghost_err_o(ghost_inv));
    typedef struct packed {
        logic [11:0] value;
        logic [2:0]  valid;
        logic [2:0]  dp;
        logic        ghost;
    } obs_t;
    obs_t sb[$];
    obs_t m = '0;
    int errors = 0, checks = 0, frames = 0;
    logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    always @(negedge clk) if (frame_o) frames++;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    // reference model of one capture of a long-held pattern
    task automatic model(input logic [2:0] en, input logic [6:0] seg, input logic dp);
        int k = -1;
        if ($countones(en) > 1) m.ghost = 1'b1;
        else if (en != 0) begin
            for (int i = 0; i < 16; i++) if (hex_tbl[i] == seg) k = i;
            for (int i = 0; i < D; i++)
                if (en[i]) begin
                    if (k >= 0) m.value[4*i +: 4] = 4'(k);
                    m.valid[i] = k >= 0;
                    m.dp[i]    = dp;
                end
        end
    endtask
    task automatic hold(input logic [2:0] en, input logic [6:0] seg, input logic dp);
        obs_t e;
        bus.digit_en = en;
        bus.seg      = seg;
        bus.dp       = dp;
        model(en, seg, dp);
        sb.push_back(m);
        step(16);
        e = sb.pop_front();
        chk("value", 32'(value_o), 32'(e.value));
        chk("valid", 32'(valid_o), 32'(e.valid));
        chk("dp", 32'(dp_o), 32'(e.dp));
        chk("ghost", 32'(ghost_o), 32'(e.ghost));
    endtask
    task automatic run_321();
        int f = frames;
        hold(3'b001, 7'h06, 1'b0);
        hold(3'b010, 7'h5B, 1'b0);
        hold(3'b100, 7'h4F, 1'b0);
        chk("value_321", 32'(value_o), 32'h321);
        chk("valid_111", 32'(valid_o), 32'h7);
        chk("frame_once", 32'(frames - f), 32'd1);
    endtask
    initial begin
        int f, eights;
        bus.digit_en = '0;
        bus.seg = '0;
        bus.dp = 1'b0;
        bus_inv.digit_en = 3'b111;
        bus_inv.seg = 7'h7F;
        bus_inv.dp = 1'b1;
        step(2);
        chk("rst_value", 32'(value_o), 0);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_dp", 32'(dp_o), 0);
        chk("rst_frame", 32'(frame_o), 0);
        chk("rst_ghost", 32'(ghost_o), 0);
        rst = 1'b0;
        step(2);
        run_321();
        f = frames;
        hold(3'b001, 7'h3F, 1'b0);
        hold(3'b001, 7'h06, 1'b0);
        chk("no_frame_repeat", 32'(frames - f), 0);
        bus.seg = 7'h7F;
        step(4);
        bus.seg = 7'h06;
        eights = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (value_o[3:0] == 4'h8) eights++;
        end
        chk("glitch_never8", 32'(eights), 0);
        chk("glitch_value", 32'(value_o[3:0]), 32'h1);
        hold(3'b001, 7'h4F, 1'b0);
        hold(3'b010, 7'h5B, 1'b1);
        hold(3'b001, 7'h49, 1'b0);
        chk("invalid_valid0", 32'(valid_o[0]), 0);
        chk("invalid_keep", 32'(value_o[3:0]), 32'h3);
        f = frames;
        hold(3'b011, 7'h06, 1'b0);
        chk("ghost_set", 32'(ghost_o), 1);
        chk("ghost_no_frame", 32'(frames - f), 0);
        bus.digit_en = '0;
        step(10);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        m = '0;
        chk("clr_ghost", 32'(ghost_o), 0);
        chk("clr_value", 32'(value_o), 0);
        chk("clr_valid", 32'(valid_o), 0);
        hold(3'b001, 7'h06, 1'b0);
        bus.digit_en = 3'b010;
        bus.seg = 7'h5B;
        step(5);
        #2 rst = 1'b1;
        #1;
        chk("arst_value", 32'(value_o), 0);
        chk("arst_valid", 32'(valid_o), 0);
        chk("arst_dp", 32'(dp_o), 0);
        chk("arst_frame", 32'(frame_o), 0);
        m = '0;
        bus.digit_en = '0;
        step(2);
        rst = 1'b0;
        step(8);
        chk("arst_no_partial", 32'(value_o), 0);
        run_321();
        bus_inv.digit_en = 3'b110;
        bus_inv.seg = ~7'h06;
        bus_inv.dp = 1'b0;
        step(16);
        chk("inv_value1", 32'(value_inv[3:0]), 32'h1);
        bus_inv.seg = ~7'h3F;
        step(16);
        chk("inv_value0", 32'(value_inv[3:0]), 0);
        chk("inv_dp", 32'(dp_inv[0]), 1);
        chk("inv_valid", 32'(valid_inv[0]), 1);
        chk("inv_ghost", 32'(ghost_inv), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
